// File: rtl/axi_lite_master_port_if.sv
// axi_lite_master_port_if: AXI4-Lite bus bundle with master and slave views
interface axi_lite_master_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic AWVALID, AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic WVALID, WREADY;
  logic [1:0] BRESP;
  logic BVALID, BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic ARVALID, ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0] RRESP;
  logic RVALID, RREADY;
  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );
  modport slave (
    input AWADDR, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_lite_master_port.sv
// axi_lite_master_port: single-outstanding AXI4-Lite initiator for a word-addressed cmd/rsp port; AXIL_MASTER_TIMEOUT_EN adds a response watchdog and DRAIN state
module axi_lite_master_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_write,
  input  logic [ADDR_WIDTH-3:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0] rsp_resp,
  axi_lite_master_port_if.master m
);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP, RSP
`ifdef AXIL_MASTER_TIMEOUT_EN
    , DRAIN
`endif
  } state_t;
  state_t st, nxt, rsp_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic [1:0] resp;
  logic aw_done, w_done, to, drn;
  logic aw_hs, w_hs, b_cap, r_cap, active;
  if (DATA_WIDTH % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("axi_lite_master_port: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES positive");
  end
  assign aw_hs = m.AWVALID && m.AWREADY;
  assign w_hs = m.WVALID && m.WREADY;
  assign b_cap = m.BVALID && m.BREADY && (st == WRITE || st == WRESP);
  assign r_cap = m.RVALID && m.RREADY && (st == READ || st == RRESP);
  assign active = st == WRITE || st == WRESP || st == READ || st == RRESP;
`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic drain;
  assign to = active && cnt == CW'(TIMEOUT_CYCLES - 1) && !b_cap && !r_cap;
  assign drn = st == DRAIN;
  assign rsp_nxt = drain ? DRAIN : IDLE;
  // watchdog counter plus the flag that routes a timed-out response through DRAIN
  always_ff @(posedge ACLK)
    if (ARESET) begin
      cnt <= '0;
      drain <= 1'b0;
    end else begin
      cnt <= active ? cnt + 1'b1 : '0;
      drain <= to ? 1'b1 : (st == RSP && rsp_ready) ? 1'b0 : drain;
    end
`else
  assign to = 1'b0;
  assign drn = 1'b0;
  assign rsp_nxt = IDLE;
`endif
  // state register
  always_ff @(posedge ACLK) st <= ARESET ? IDLE : nxt;
  // next-state: early B/R responses win over the address-phase bookkeeping
  always_comb begin
    nxt = st;
    case (st)
      IDLE:  nxt = cmd_valid ? (cmd_write ? WRITE : READ) : IDLE;
      WRITE: nxt = (b_cap || to) ? RSP : ((aw_done || aw_hs) && (w_done || w_hs)) ? WRESP : WRITE;
      WRESP: nxt = (b_cap || to) ? RSP : WRESP;
      READ:  nxt = (r_cap || to) ? RSP : (m.ARVALID && m.ARREADY) ? RRESP : READ;
      RRESP: nxt = (r_cap || to) ? RSP : RRESP;
      RSP:   nxt = rsp_ready ? rsp_nxt : RSP;
`ifdef AXIL_MASTER_TIMEOUT_EN
      DRAIN: nxt = ((m.BVALID && m.BREADY) || (m.RVALID && m.RREADY)) ? IDLE : DRAIN;
`endif
      default: nxt = IDLE;
    endcase
  end
  // command capture, per-channel handshake tracking and response capture
  always_ff @(posedge ACLK)
    if (ARESET) begin
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rdata <= '0;
      resp <= 2'b00;
    end else begin
      if (st == IDLE && cmd_valid) begin
        addr <= {cmd_addr, 2'b00};
        wdata <= cmd_wdata;
        wstrb <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (to) begin
        rdata <= '0;
        resp <= 2'b11;
      end
      if (b_cap) begin
        rdata <= '0;
        resp <= m.BRESP;
      end
      if (r_cap) begin
        rdata <= m.RDATA;
        resp <= m.RRESP;
      end
    end
  // outputs decoded from state; VALIDs drop the cycle after their own handshake
  always_comb begin
    cmd_ready = st == IDLE;
    rsp_valid = st == RSP;
    m.AWVALID = st == WRITE && !aw_done;
    m.WVALID = st == WRITE && !w_done;
    m.BREADY = st == WRITE || st == WRESP || drn;
    m.ARVALID = st == READ;
    m.RREADY = st == READ || st == RRESP || drn;
  end
  assign m.AWADDR = addr;
  assign m.ARADDR = addr;
  assign m.WDATA = wdata;
  assign m.WSTRB = wstrb;
  assign rsp_rdata = rdata;
  assign rsp_resp = resp;
endmodule

// File: doc/axi_lite_master_port.md
# axi_lite_master_port

Single-outstanding AXI4-Lite initiator that converts a simple word-addressed command/response interface into AXI4-Lite read and write transactions. It sits on the accelerator side and drives the AXI4-Lite slave ports of the SSRAM bridges and any other AXI4-Lite slave in the design. Addresses on the command side are word addresses, using the same indexing as the SSRAM interfaces; the block appends the two byte-offset bits.

## Interface
- DATA_WIDTH, 32, AXI and command data width; multiple of 8
- ADDR_WIDTH, 16, AXI byte-address width
- TIMEOUT_CYCLES, 1024, response watchdog limit; used only when the timeout feature is compiled in
- ACLK  in  1  clock; all logic on the rising edge
- ARESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH-2  word address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  AXI response code; 2'b11 = timeout
- AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths

## Operation
- States: IDLE, WRITE (AW and/or W pending), WRESP, READ (AR pending), RRESP, RSP, and DRAIN (DRAIN exists only with the timeout feature).
- IDLE: cmd_ready = 1. On the cmd handshake:
  - register address {cmd_addr, 2'b00}, data and strobes;
  - go to WRITE if cmd_write = 1, otherwise READ.
- WRITE:
  - AWVALID and WVALID rise together.
  - Each drops independently, in the cycle after its own handshake.
  - When both handshakes are complete, go to WRESP. If both complete in the same cycle, go to WRESP in the next cycle.
- BREADY is 1 throughout WRITE and WRESP, so a B response that arrives early is accepted.
  - On B handshake: capture BRESP, set rsp_rdata = 0, go to RSP.
- READ: ARVALID stays 1 until the AR handshake, then go to RRESP.
- RREADY is 1 throughout READ and RRESP.
  - On R handshake: capture RDATA and RRESP, go to RSP.
- RSP: rsp_valid = 1 with stable rsp_rdata and rsp_resp until rsp_ready is sampled high, then go to IDLE.
- Only one transaction is ever outstanding. AXI outputs hold stable while VALID is high and not yet accepted.
- Reset values:
  - all VALID and READY outputs = 0;
  - AWADDR, ARADDR, WDATA, WSTRB = 0;
  - rsp_valid = 0, rsp_rdata = 0, rsp_resp = 2'b00;
  - state = IDLE.
- Reset mid-transaction abandons the transaction immediately. Slaves are reset on the same ARESET.

## Timing
- Command accepted at edge N. AWVALID/WVALID (or ARVALID) are high from N+1.
- Zero-wait slave, write: AW+W handshake at N+1, B handshake at N+2, rsp_valid at N+3.
- Zero-wait slave, read: AR handshake at N+1, R handshake at N+2 (the SSRAM bridge returns RVALID two cycles after AR), rsp_valid from N+3 or N+4.
- cmd_ready returns high in the cycle after the rsp handshake, so the minimum command spacing is 4 cycles.
- rsp_valid is registered; no combinational path from rsp_ready to any AXI output.

## Configuration
- AXIL_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to WRITE or READ and counts every cycle in WRITE, WRESP, READ and RRESP.
  - When it reaches TIMEOUT_CYCLES: drop all VALIDs, present rsp_resp = 2'b11 and rsp_rdata = 0 in RSP, and set a drain flag.
  - After the timeout response is consumed, the block enters DRAIN instead of IDLE. DRAIN holds BREADY and RREADY at 1 and discards one stale B or R, then goes to IDLE.
  - Counter width: $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter and no DRAIN state; the block waits indefinitely.

## Test plan
- Write addr 0x0010, data 0xDEADBEEF, wstrb 0xF, zero-wait slave -> AWADDR = 0x0040, WDATA = 0xDEADBEEF, rsp_resp = 0 at N+3, cmd_ready high again at N+4.
- Read word 0x0010 after that write -> ARADDR = 0x0040, rsp_rdata = 0xDEADBEEF, rsp_resp = 0.
- Slave delays AWREADY 3 cycles and WREADY 0 cycles -> WVALID drops at N+2, AWVALID drops at N+5, no B accepted before both handshakes, single response.
- Slave returns BRESP = 2'b10 and rsp_ready held low for 5 cycles -> rsp_valid and rsp_resp = 2'b10 stable for 6 cycles, cmd_ready low throughout.
- ARESET asserted for one cycle while ARVALID = 1 -> next cycle all VALID/READY = 0, rsp_valid = 0, cmd_ready = 1.
- With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never asserts ARREADY -> rsp_resp = 2'b11 after 8 cycles; a late R is then accepted in DRAIN and discarded, and the next read completes normally.
